// File: rtl/tpu_pkg.sv
// Shared accumulator-drain types and default widths.
// Pure declarations; no logic, no latency, no flow control.
package tpu_pkg;

  localparam int ACC_DATA_W = 32;
  localparam int ACC_ADDR_W = 8;
  localparam int ACC_DEPTH  = 2;

  typedef enum logic [1:0] {
    DR_IDLE,
    DR_SEND,
    DR_DONE
  } drain_state_t;

  // Index counter needs at least one bit even for a single-entry bank.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/acc_drain_if.sv
// Unified-buffer write port: one beat per cycle when ub_valid & ub_ready.
// Master holds addr/data/valid stable while ub_ready is low.
interface acc_drain_if
  import tpu_pkg::*;
#(
  parameter int DATA_W = ACC_DATA_W,
  parameter int ADDR_W = ACC_ADDR_W
);

  logic              ub_valid;
  logic              ub_ready;
  logic [ADDR_W-1:0] ub_addr;
  logic [DATA_W-1:0] ub_data;

  modport master (
    output ub_valid,
    output ub_addr,
    output ub_data,
    input  ub_ready
  );

  modport slave (
    input  ub_valid,
    input  ub_addr,
    input  ub_data,
    output ub_ready
  );

endinterface

// File: rtl/edge_detect_rise.sv
// Registered rising-edge detector: rise = sig_in & ~previous sig_in, same cycle as sig_in rises.
// No backpressure; a held-high level produces exactly one pulse.
module edge_detect_rise (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic rise
);

  logic sig_q;
  logic sig_d;

  always_comb begin
    sig_d = sig_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign rise = sig_in & ~sig_q;

endmodule

// File: rtl/acc_drain.sv
// Snapshots DEPTH accumulator words on a full edge and streams them to the UB; first beat 1 cycle
// after capture, done 1 cycle after last accept. ub_ready low stalls with beat held stable.
module acc_drain
  import tpu_pkg::*;
#(
  parameter int DATA_W = ACC_DATA_W,
  parameter int DEPTH  = ACC_DEPTH,
  parameter int ADDR_W = ACC_ADDR_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    acc_full,
  input  logic [DEPTH*DATA_W-1:0] acc_words,
  input  logic [ADDR_W-1:0]       base_addr,
  acc_drain_if.master             ub,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);

  localparam int               IDX_W    = idx_width(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic capture;

  edge_detect_rise u_full_edge (
    .clk    (clk),
    .reset  (reset),
    .sig_in (acc_full),
    .rise   (capture)
  );

  drain_state_t      state_q,    state_d;
  logic [IDX_W-1:0]  idx_q,      idx_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [DATA_W-1:0] snap_q [DEPTH];
  logic [DATA_W-1:0] snap_d [DEPTH];
  logic              ub_valid_q, ub_valid_d;
  logic [ADDR_W-1:0] ub_addr_q,  ub_addr_d;
  logic [DATA_W-1:0] ub_data_q,  ub_data_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
  logic              overrun_q,  overrun_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    snap_d     = snap_q;
    ub_valid_d = ub_valid_q;
    ub_addr_d  = ub_addr_q;
    ub_data_d  = ub_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    overrun_d  = overrun_q;

    case (state_q)
      DR_IDLE: begin
        if (capture) begin
          for (int i = 0; i < DEPTH; i++) begin
            snap_d[i] = acc_words[i*DATA_W +: DATA_W];
          end
          addr_d     = base_addr;
          idx_d      = '0;
          busy_d     = 1'b1;
          ub_valid_d = 1'b1;
          ub_addr_d  = base_addr;
          ub_data_d  = acc_words[0 +: DATA_W];
          state_d    = DR_SEND;
        end
      end

      DR_SEND: begin
        // The edge is consumed here; the producer must re-raise full for another tile.
        if (capture) begin
          overrun_d = 1'b1;
        end
        if (ub_valid_q && ub.ub_ready) begin
          if (idx_q == LAST_IDX) begin
            ub_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            state_d    = DR_DONE;
          end else begin
            idx_d     = idx_q + 1'b1;
            ub_addr_d = addr_q + ADDR_W'(idx_d);
            ub_data_d = snap_q[idx_d];
          end
        end
      end

      DR_DONE: begin
        if (capture) begin
          overrun_d = 1'b1;
        end
        state_d = DR_IDLE;
      end

      default: begin
        state_d = DR_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= DR_IDLE;
      idx_q      <= '0;
      addr_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        snap_q[i] <= '0;
      end
      ub_valid_q <= 1'b0;
      ub_addr_q  <= '0;
      ub_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      snap_q     <= snap_d;
      ub_valid_q <= ub_valid_d;
      ub_addr_q  <= ub_addr_d;
      ub_data_q  <= ub_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
    end
  end

  assign ub.ub_valid = ub_valid_q;
  assign ub.ub_addr  = ub_addr_q;
  assign ub.ub_data  = ub_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_acc_drain.sv
// Bench for acc_drain: expected UB beats queued at stimulus time, popped as the DUT accepts them.
module tb_acc_drain;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        acc_full = 1'b0;
  logic [63:0] acc_words = '0;
  logic [7:0]  base_addr = '0;
  logic        busy;
  logic        done;
  logic        overrun;

  int    total = 0;
  int    bad = 0;
  beat_t exp_q[$];
  beat_t exp_b;

  acc_drain_if #(.DATA_W(32), .ADDR_W(8)) ub ();

  acc_drain #(.DATA_W(32), .DEPTH(2), .ADDR_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .acc_full  (acc_full),
    .acc_words (acc_words),
    .base_addr (base_addr),
    .ub        (ub),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Inputs change at posedge+1, so values seen here are the ones the next edge uses.
  always @(negedge clk) begin
    if (!reset && ub.ub_valid && ub.ub_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_extra_beat got addr=%0h data=%0h want no beat", ub.ub_addr, ub.ub_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (ub.ub_addr !== exp_b.a || ub.ub_data !== exp_b.d) begin
          bad++;
          $display("FAIL sb_beat got addr=%0h data=%0h want addr=%0h data=%0h",
                   ub.ub_addr, ub.ub_data, exp_b.a, exp_b.d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL %s_done_timeout got done=%0b want 1", name, done);
    end
  endtask

  task automatic check_sb_empty(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_sb_left got %0d beats pending want 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ub.ub_ready = 1'b0;
    cyc();
    cyc();
    total++;
    if ({ub.ub_valid, ub.ub_addr, ub.ub_data, busy, done, overrun} !== 44'h0) begin
      bad++;
      $display("FAIL reset_outputs got v=%0b a=%0h d=%0h busy=%0b done=%0b ovr=%0b want all 0",
               ub.ub_valid, ub.ub_addr, ub.ub_data, busy, done, overrun);
    end
    reset = 1'b0;
    cyc();
    total++;
    if (ub.ub_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle got v=%0b busy=%0b want 0 0", ub.ub_valid, busy);
    end
  endtask

  task automatic test_basic();
    acc_words = {32'd9, 32'd7};
    base_addr = 8'h10;
    ub.ub_ready = 1'b1;
    exp_q.push_back('{a: 8'h10, d: 32'd7});
    exp_q.push_back('{a: 8'h11, d: 32'd9});
    acc_full = 1'b1;
    cyc();
    total++;
    if (ub.ub_valid !== 1'b1 || ub.ub_addr !== 8'h10 || ub.ub_data !== 32'd7 || busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_beat0 got v=%0b a=%0h d=%0h busy=%0b want 1 10 7 1",
               ub.ub_valid, ub.ub_addr, ub.ub_data, busy);
    end
    cyc();
    total++;
    if (ub.ub_valid !== 1'b1 || ub.ub_addr !== 8'h11 || ub.ub_data !== 32'd9) begin
      bad++;
      $display("FAIL basic_beat1 got v=%0b a=%0h d=%0h want 1 11 9", ub.ub_valid, ub.ub_addr, ub.ub_data);
    end
    cyc();
    total++;
    if (done !== 1'b1 || ub.ub_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_done got done=%0b v=%0b busy=%0b want 1 0 0", done, ub.ub_valid, busy);
    end
    cyc();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL basic_done_width got done=%0b want 0", done);
    end
    acc_full = 1'b0;
    check_sb_empty("basic");
  endtask

  task automatic test_backpressure();
    cyc();
    acc_words = {32'd9, 32'd7};
    base_addr = 8'h10;
    ub.ub_ready = 1'b0;
    exp_q.push_back('{a: 8'h10, d: 32'd7});
    exp_q.push_back('{a: 8'h11, d: 32'd9});
    acc_full = 1'b1;
    cyc();
    for (int k = 0; k < 4; k++) begin
      total++;
      if (ub.ub_valid !== 1'b1 || ub.ub_addr !== 8'h10 || ub.ub_data !== 32'd7) begin
        bad++;
        $display("FAIL bp_hold%0d got v=%0b a=%0h d=%0h want 1 10 7",
                 k, ub.ub_valid, ub.ub_addr, ub.ub_data);
      end
      if (k < 3) cyc();
    end
    ub.ub_ready = 1'b1;
    cyc();
    total++;
    if (ub.ub_valid !== 1'b1 || ub.ub_addr !== 8'h11 || ub.ub_data !== 32'd9) begin
      bad++;
      $display("FAIL bp_beat1 got v=%0b a=%0h d=%0h want 1 11 9", ub.ub_valid, ub.ub_addr, ub.ub_data);
    end
    cyc();
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL bp_done got done=%0b want 1", done);
    end
    acc_full = 1'b0;
    cyc();
    check_sb_empty("bp");
  endtask

  task automatic test_wrap();
    acc_words = {32'h0000_000B, 32'h0000_000A};
    base_addr = 8'hFF;
    ub.ub_ready = 1'b1;
    exp_q.push_back('{a: 8'hFF, d: 32'h0A});
    exp_q.push_back('{a: 8'h00, d: 32'h0B});
    acc_full = 1'b1;
    cyc();
    wait_done("wrap");
    acc_full = 1'b0;
    cyc();
    check_sb_empty("wrap");
  endtask

  task automatic test_overrun();
    acc_words = {32'h222, 32'h111};
    base_addr = 8'h40;
    ub.ub_ready = 1'b0;
    exp_q.push_back('{a: 8'h40, d: 32'h111});
    exp_q.push_back('{a: 8'h41, d: 32'h222});
    acc_full = 1'b1;
    cyc();
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL ovr_pre got ovr=%0b want 0", overrun);
    end
    acc_full = 1'b0;
    cyc();
    acc_words = {32'd2, 32'd1};
    base_addr = 8'h80;
    acc_full = 1'b1;
    cyc();
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL ovr_set got ovr=%0b want 1", overrun);
    end
    ub.ub_ready = 1'b1;
    wait_done("ovr");
    for (int k = 0; k < 6; k++) begin
      cyc();
      total++;
      if (ub.ub_valid !== 1'b0 || overrun !== 1'b1) begin
        bad++;
        $display("FAIL ovr_after%0d got v=%0b ovr=%0b want 0 1", k, ub.ub_valid, overrun);
      end
    end
    acc_full = 1'b0;
    cyc();
    check_sb_empty("ovr");
  endtask

  task automatic test_reset_mid_drain();
    acc_words = {32'd4, 32'd3};
    base_addr = 8'h20;
    ub.ub_ready = 1'b0;
    acc_full = 1'b1;
    cyc();
    total++;
    if (ub.ub_valid !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_pre got v=%0b busy=%0b want 1 1", ub.ub_valid, busy);
    end
    reset = 1'b1;
    acc_full = 1'b0;
    cyc();
    total++;
    if ({ub.ub_valid, ub.ub_addr, ub.ub_data, busy, done, overrun} !== 44'h0) begin
      bad++;
      $display("FAIL rst_mid_outputs got v=%0b a=%0h d=%0h busy=%0b done=%0b ovr=%0b want all 0",
               ub.ub_valid, ub.ub_addr, ub.ub_data, busy, done, overrun);
    end
    reset = 1'b0;
    cyc();
    acc_words = {32'h66, 32'h55};
    base_addr = 8'h24;
    ub.ub_ready = 1'b1;
    exp_q.push_back('{a: 8'h24, d: 32'h55});
    exp_q.push_back('{a: 8'h25, d: 32'h66});
    acc_full = 1'b1;
    cyc();
    wait_done("rst_fresh");
    acc_full = 1'b0;
    cyc();
    check_sb_empty("rst_fresh");
  endtask

  task automatic test_zero_level_hold();
    int dones;
    dones = 0;
    acc_words = {32'd5, 32'd0};
    base_addr = 8'h30;
    ub.ub_ready = 1'b1;
    exp_q.push_back('{a: 8'h30, d: 32'd0});
    exp_q.push_back('{a: 8'h31, d: 32'd5});
    acc_full = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (done === 1'b1) dones++;
    end
    total++;
    if (dones != 1) begin
      bad++;
      $display("FAIL hold_done_count got %0d want 1", dones);
    end
    total++;
    if (ub.ub_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL hold_idle got v=%0b busy=%0b want 0 0", ub.ub_valid, busy);
    end
    acc_full = 1'b0;
    cyc();
    check_sb_empty("hold");
  endtask

  initial begin
    ub.ub_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_overrun();
    test_reset_mid_drain();
    test_zero_level_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
